// File: rtl/axis_packet_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : axis_packet_rr_arbiter                                     |
// | Description : Packet-atomic round-robin arbiter sharing one outgoing     |
// |               AXI-Stream link between N_PORTS inputs. A grant is taken   |
// |               in IDLE and held until the TLAST beat of the granted port  |
// |               is accepted. The output side is a single register stage.   |
// | Ports       : clk, rst_n (async, active-low)                             |
// |               s_tvalid/s_tready/s_tlast [N_PORTS], s_tdata, s_tid        |
// |               (port p in slice p of the packed buses)                    |
// |               m_tvalid/m_tready/m_tdata/m_tid/m_tlast (registered out)   |
// |               grant (one-hot, zero when idle), busy (packet locked)      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module axis_packet_rr_arbiter #(
  parameter int N_PORTS    = 5,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 3,
  parameter int PTR_WIDTH  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_PORTS-1:0]             s_tvalid,
  output logic [N_PORTS-1:0]             s_tready,
  input  logic [N_PORTS*DATA_WIDTH-1:0]  s_tdata,
  input  logic [N_PORTS*ID_WIDTH-1:0]    s_tid,
  input  logic [N_PORTS-1:0]             s_tlast,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [DATA_WIDTH-1:0]          m_tdata,
  output logic [ID_WIDTH-1:0]            m_tid,
  output logic                           m_tlast,
  output logic [N_PORTS-1:0]             grant,
  output logic                           busy
);

  localparam logic [0:0]           S_IDLE    = 1'b0;
  localparam logic [0:0]           S_LOCKED  = 1'b1;
  localparam logic [PTR_WIDTH:0]   C_NPORTS  = (PTR_WIDTH+1)'(N_PORTS);

  logic [0:0]             r_state;
  logic [PTR_WIDTH-1:0]   r_ptr;
  logic [N_PORTS-1:0]     r_grant;
  logic                   r_m_tvalid;
  logic [DATA_WIDTH-1:0]  r_m_tdata;
  logic [ID_WIDTH-1:0]    r_m_tid;
  logic                   r_m_tlast;

  logic                   w_out_ready;
  logic [N_PORTS-1:0]     w_hs;
  logic                   w_accept;
  logic                   w_accept_last;
  logic                   w_any;
  logic [PTR_WIDTH-1:0]   w_sel;
  logic [PTR_WIDTH:0]     w_idx;
  logic [PTR_WIDTH:0]     w_sel_p1;
  logic [PTR_WIDTH-1:0]   w_ptr_next;
  logic [N_PORTS-1:0]     w_sel_onehot;
  logic [DATA_WIDTH-1:0]  w_mux_data;
  logic [ID_WIDTH-1:0]    w_mux_id;
  logic                   w_mux_last;

  // The output register can take a new beat when empty or draining this cycle.
  assign w_out_ready   = ~r_m_tvalid | m_tready;
  // r_grant is all-zero in IDLE, so this also forces s_tready low there.
  assign s_tready      = r_grant & {N_PORTS{w_out_ready}};
  assign w_hs          = s_tvalid & s_tready;
  assign w_accept      = |w_hs;
  assign w_accept_last = |(w_hs & s_tlast);

  // Round-robin search: first requester at r_ptr, r_ptr+1, ... modulo N_PORTS.
  // The index is kept one bit wider so the wrap is a compare-and-subtract.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      w_idx = {1'b0, r_ptr} + (PTR_WIDTH+1)'(i);
      if (w_idx >= C_NPORTS) begin
        w_idx = w_idx - C_NPORTS;
      end
      if (!w_any && s_tvalid[w_idx[PTR_WIDTH-1:0]]) begin
        w_any = 1'b1;
        w_sel = w_idx[PTR_WIDTH-1:0];
      end
    end
  end

  // Pointer moves just past the winner; with one port this is always 0.
  always_comb begin
    w_sel_p1 = {1'b0, w_sel} + (PTR_WIDTH+1)'(1);
    if (w_sel_p1 >= C_NPORTS) begin
      w_sel_p1 = '0;
    end
    w_ptr_next = w_sel_p1[PTR_WIDTH-1:0];
  end

  assign w_sel_onehot = N_PORTS'(1) << w_sel;

  // AND-OR mux on the one-hot grant: non-granted ports never reach the output.
  always_comb begin
    w_mux_data = '0;
    w_mux_id   = '0;
    w_mux_last = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (r_grant[p]) begin
        w_mux_data = w_mux_data | s_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        w_mux_id   = w_mux_id   | s_tid[p*ID_WIDTH +: ID_WIDTH];
        w_mux_last = w_mux_last | s_tlast[p];
      end
    end
  end

  // Arbitration state: grant taken in IDLE, released on the accepted TLAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_any) begin
        r_grant <= w_sel_onehot;
        r_ptr   <= w_ptr_next;
        r_state <= S_LOCKED;
      end
    end else begin
      if (w_accept_last) begin
        r_grant <= '0;
        r_state <= S_IDLE;
      end
    end
  end

  // Output stage: payload only loads on accept, so it holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tid    <= '0;
      r_m_tlast  <= 1'b0;
    end else if (w_accept) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= w_mux_data;
      r_m_tid    <= w_mux_id;
      r_m_tlast  <= w_mux_last;
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_tvalid = r_m_tvalid;
  assign m_tdata  = r_m_tdata;
  assign m_tid    = r_m_tid;
  assign m_tlast  = r_m_tlast;
  assign grant    = r_grant;
  assign busy     = (r_state == S_LOCKED);

`ifndef SYNTHESIS
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(r_grant));

  a_out_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (r_m_tvalid && !m_tready) |=>
      (r_m_tvalid && $stable(r_m_tdata) && $stable(r_m_tid) && $stable(r_m_tlast)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_axis_packet_rr_arbiter                                  |
// | Description : Self-checking bench: per-cycle expectation table plus a   |
// |               beat scoreboard filled in expected service order.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_axis_packet_rr_arbiter;

  localparam int NP = 5;
  localparam int DW = 8;
  localparam int IW = 3;

  localparam int MG = 1;   // check grant
  localparam int MB = 2;   // check busy
  localparam int MV = 4;   // check m_tvalid
  localparam int MD = 8;   // check m_tdata
  localparam int ML = 16;  // check m_tlast
  localparam int MS = 32;  // check s_tready

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP-1:0]     s_tvalid = '0;
  logic [NP-1:0]     s_tready;
  logic [NP*DW-1:0]  s_tdata = '0;
  logic [NP*IW-1:0]  s_tid = '0;
  logic [NP-1:0]     s_tlast = '0;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic [DW-1:0]     m_tdata;
  logic [IW-1:0]     m_tid;
  logic              m_tlast;
  logic [NP-1:0]     grant;
  logic              busy;

  always #5 clk = ~clk;

  axis_packet_rr_arbiter #(
    .N_PORTS    (NP),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tdata  (s_tdata),
    .s_tid    (s_tid),
    .s_tlast  (s_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tid    (m_tid),
    .m_tlast  (m_tlast),
    .grant    (grant),
    .busy     (busy)
  );

  typedef struct {
    int         test;
    int         cyc;
    logic       mrdy;
    int         mask;
    logic [4:0] grant;
    logic       busy;
    logic       mv;
    logic [7:0] md;
    logic       ml;
    logic [4:0] srdy;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [2:0] id;
    logic       l;
  } beat_t;

  vec_t   vecs[$];
  beat_t  sb_q[$];

  logic [7:0] src_data [NP][8];
  int         src_dly  [NP][8];
  int         src_len  [NP];
  int         src_pos  [NP];
  int         src_cnt  [NP];
  logic [NP-1:0] hs;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void addv(input int t, input int c, input logic mr, input int m,
                               input logic [4:0] g, input logic b, input logic mv,
                               input logic [7:0] md, input logic ml, input logic [4:0] sr);
    vec_t v;
    v.test = t; v.cyc = c; v.mrdy = mr; v.mask = m;
    v.grant = g; v.busy = b; v.mv = mv; v.md = md; v.ml = ml; v.srdy = sr;
    vecs.push_back(v);
  endfunction

  task automatic clear_srcs();
    for (int p = 0; p < NP; p++) begin
      src_len[p] = 0;
      src_pos[p] = 0;
      src_cnt[p] = 0;
    end
  endtask

  // Loads a packet on port p and records its beats as the next expected output.
  task automatic load_pkt(input int p, input int n, input logic [7:0] base,
                          input int start_dly, input int gap_k, input int gap_len);
    beat_t b;
    src_len[p] = n;
    src_pos[p] = 0;
    src_cnt[p] = start_dly;
    for (int k = 0; k < 8; k++) src_dly[p][k] = 0;
    if (gap_k > 0 && gap_k < 8) src_dly[p][gap_k] = gap_len;
    for (int k = 0; k < n; k++) begin
      src_data[p][k] = base + 8'(k);
      b.d  = base + 8'(k);
      b.id = 3'(p);
      b.l  = (k == n - 1);
      sb_q.push_back(b);
    end
  endtask

  task automatic drive_srcs();
    for (int p = 0; p < NP; p++) begin
      if (src_pos[p] < src_len[p] && src_cnt[p] == 0) begin
        s_tvalid[p]          = 1'b1;
        s_tdata[p*DW +: DW]  = src_data[p][src_pos[p]];
        s_tlast[p]           = (src_pos[p] == src_len[p] - 1);
      end else begin
        s_tvalid[p]          = 1'b0;
        s_tdata[p*DW +: DW]  = 8'hEE;
        s_tlast[p]           = 1'b1;
      end
      s_tid[p*IW +: IW] = IW'(p);
    end
  endtask

  // One clock cycle, entered and left just after the rising edge.
  task automatic step(input int t, input int c);
    beat_t b;
    m_tready = 1'b1;
    foreach (vecs[i]) if (vecs[i].test == t && vecs[i].cyc == c) m_tready = vecs[i].mrdy;
    drive_srcs();
    @(negedge clk);
    foreach (vecs[i]) begin
      if (vecs[i].test == t && vecs[i].cyc == c) begin
        if ((vecs[i].mask & MG) != 0) chk($sformatf("t%0d c%0d grant", t, c), 32'(grant), 32'(vecs[i].grant));
        if ((vecs[i].mask & MB) != 0) chk($sformatf("t%0d c%0d busy", t, c), 32'(busy), 32'(vecs[i].busy));
        if ((vecs[i].mask & MV) != 0) chk($sformatf("t%0d c%0d m_tvalid", t, c), 32'(m_tvalid), 32'(vecs[i].mv));
        if ((vecs[i].mask & MD) != 0) chk($sformatf("t%0d c%0d m_tdata", t, c), 32'(m_tdata), 32'(vecs[i].md));
        if ((vecs[i].mask & ML) != 0) chk($sformatf("t%0d c%0d m_tlast", t, c), 32'(m_tlast), 32'(vecs[i].ml));
        if ((vecs[i].mask & MS) != 0) chk($sformatf("t%0d c%0d s_tready", t, c), 32'(s_tready), 32'(vecs[i].srdy));
      end
    end
    if (m_tvalid && m_tready) begin
      if (sb_q.size() == 0) begin
        chk($sformatf("t%0d c%0d unexpected beat", t, c), {21'd0, m_tdata, m_tid, m_tlast}, 32'hFFFF_FFFF);
      end else begin
        b = sb_q.pop_front();
        chk($sformatf("t%0d c%0d beat{data,id,last}", t, c),
            {21'd0, m_tdata, m_tid, m_tlast}, {21'd0, b.d, b.id, b.l});
      end
    end
    hs = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      if (hs[p]) begin
        src_pos[p]++;
        if (src_pos[p] < src_len[p]) src_cnt[p] = src_dly[p][src_pos[p]];
      end else if (src_cnt[p] > 0) begin
        src_cnt[p]--;
      end
    end
  endtask

  task automatic run(input int t, input int ncyc, input bit drained);
    for (int c = 0; c < ncyc; c++) step(t, c);
    if (drained) chk($sformatf("t%0d scoreboard left", t), 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_srcs();
    sb_q.delete();
    drive_srcs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // T1: single 3-beat packet on port 2
    addv(1, 0, 1, MG|MB|MV|MS, 5'b00000, 0, 0, 8'h00, 0, 5'b00000);
    addv(1, 1, 1, MG|MB|MV|MS, 5'b00100, 1, 0, 8'h00, 0, 5'b00100);
    addv(1, 2, 1, MG|MB|MV|MD|ML|MS, 5'b00100, 1, 1, 8'hA1, 0, 5'b00100);
    addv(1, 3, 1, MG|MB|MV|MD|ML, 5'b00100, 1, 1, 8'hA2, 0, 5'b00000);
    addv(1, 4, 1, MG|MB|MV|MD|ML|MS, 5'b00000, 0, 1, 8'hA3, 1, 5'b00000);
    addv(1, 5, 1, MG|MB|MV, 5'b00000, 0, 0, 8'h00, 0, 5'b00000);
    // T2: pointer left at 3 -> port 3 before port 0
    addv(2, 1, 1, MG, 5'b01000, 1, 0, 8'h00, 0, 5'b00000);
    addv(2, 3, 1, MG, 5'b00001, 1, 0, 8'h00, 0, 5'b00000);
    // T3: all ports, from reset
    addv(3, 1, 1, MG, 5'b00001, 1, 0, 8'h00, 0, 5'b00000);
    addv(3, 2, 1, MG|MB, 5'b00000, 0, 0, 8'h00, 0, 5'b00000);
    addv(3, 3, 1, MG, 5'b00010, 1, 0, 8'h00, 0, 5'b00000);
    addv(3, 5, 1, MG, 5'b00100, 1, 0, 8'h00, 0, 5'b00000);
    addv(3, 7, 1, MG, 5'b01000, 1, 0, 8'h00, 0, 5'b00000);
    addv(3, 9, 1, MG, 5'b10000, 1, 0, 8'h00, 0, 5'b00000);
    addv(3, 10, 1, MG|MB, 5'b00000, 0, 0, 8'h00, 0, 5'b00000);
    // T4: lock through a mid-packet gap
    addv(4, 1, 1, MG, 5'b00010, 1, 0, 8'h00, 0, 5'b00000);
    addv(4, 3, 1, MG|MB|MS, 5'b00010, 1, 0, 8'h00, 0, 5'b00010);
    addv(4, 4, 1, MG|MB|MS, 5'b00010, 1, 0, 8'h00, 0, 5'b00010);
    addv(4, 7, 1, MG|MB, 5'b00000, 0, 0, 8'h00, 0, 5'b00000);
    addv(4, 8, 1, MG, 5'b00001, 1, 0, 8'h00, 0, 5'b00000);
    // T5: backpressure holding 0x5C
    addv(5, 3, 0, MV|MD|MS, 5'b00000, 0, 1, 8'h5C, 0, 5'b00000);
    addv(5, 4, 0, MV|MD|MS, 5'b00000, 0, 1, 8'h5C, 0, 5'b00000);
    addv(5, 5, 0, MV|MD|MS, 5'b00000, 0, 1, 8'h5C, 0, 5'b00000);
    addv(5, 6, 1, MV|MD|MS, 5'b00000, 0, 1, 8'h5C, 0, 5'b00100);
    addv(5, 7, 1, MV|MD|ML, 5'b00000, 0, 1, 8'h5D, 1, 5'b00000);
    // T6: pointer wrap 4 -> 0
    addv(6, 1, 1, MG, 5'b01000, 1, 0, 8'h00, 0, 5'b00000);
    addv(6, 3, 1, MG, 5'b10000, 1, 0, 8'h00, 0, 5'b00000);
    addv(6, 5, 1, MG, 5'b00001, 1, 0, 8'h00, 0, 5'b00000);
    // T7/T8: reset mid-packet, then pointer restarts at 0
    addv(7, 1, 1, MG, 5'b01000, 1, 0, 8'h00, 0, 5'b00000);
    addv(8, 1, 1, MG, 5'b01000, 1, 0, 8'h00, 0, 5'b00000);
    addv(8, 3, 1, MG, 5'b10000, 1, 0, 8'h00, 0, 5'b00000);

    clear_srcs();
    drive_srcs();
    repeat (3) @(posedge clk);
    #1;
    chk("reset m_tvalid", 32'(m_tvalid), 32'd0);
    chk("reset m_tdata",  32'(m_tdata),  32'd0);
    chk("reset m_tid",    32'(m_tid),    32'd0);
    chk("reset m_tlast",  32'(m_tlast),  32'd0);
    chk("reset grant",    32'(grant),    32'd0);
    chk("reset busy",     32'(busy),     32'd0);
    chk("reset s_tready", 32'(s_tready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    load_pkt(2, 3, 8'hA1, 0, -1, 0);
    run(1, 7, 1);

    load_pkt(3, 1, 8'h31, 0, -1, 0);
    load_pkt(0, 1, 8'h01, 0, -1, 0);
    run(2, 6, 1);

    do_reset();
    for (int p = 0; p < NP; p++) load_pkt(p, 1, 8'h40 + 8'(p), 0, -1, 0);
    run(3, 12, 1);

    load_pkt(1, 4, 8'h10, 0, 2, 2);
    load_pkt(0, 1, 8'h05, 2, -1, 0);
    run(4, 11, 1);

    load_pkt(2, 3, 8'h5B, 0, -1, 0);
    run(5, 10, 1);

    load_pkt(3, 1, 8'h33, 0, -1, 0);
    load_pkt(4, 1, 8'h44, 2, -1, 0);
    load_pkt(0, 1, 8'h04, 2, -1, 0);
    run(6, 8, 1);

    load_pkt(3, 4, 8'h70, 0, -1, 0);
    run(7, 3, 0);
    // Beat index 2 is on the bus now; pull reset in the middle of the cycle.
    drive_srcs();
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset m_tvalid", 32'(m_tvalid), 32'd0);
    chk("midreset grant",    32'(grant),    32'd0);
    chk("midreset busy",     32'(busy),     32'd0);
    chk("midreset s_tready", 32'(s_tready), 32'd0);
    clear_srcs();
    sb_q.delete();
    drive_srcs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    load_pkt(3, 1, 8'h83, 0, -1, 0);
    load_pkt(4, 1, 8'h84, 0, -1, 0);
    run(8, 6, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
